// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states and
// the datapath mux select codes driven by the controller.
package multicycle_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXEC    = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // Successor of DECODE; S_FETCH doubles as the "undefined opcode" answer.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEM_ADR;
            OP_RTYPE:     return S_EXEC;
            OP_BEQ:       return S_BRANCH;
            OP_ADDI:      return S_ADDI_EX;
            OP_J:         return S_JUMP;
            default:      return S_FETCH;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Counts stalled memory cycles; expired flags that the wait budget is used up.
module mem_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count;

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/writeback and
// decodes datapath control from the current state, mem_ready and zero_f.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_f,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_en,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                reg_write,
    output logic                reg_dest,
    output logic                mem_t_reg,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [3:0]          state_o
);

    state_t state;
    logic   in_mem;
    logic   expired;
    logic   timeout;
    logic   branch;

    assign in_mem  = is_mem_state(state);
    assign timeout = in_mem && !mem_ready && expired;

    // Cleared whenever a memory state is left or not occupied, so every entry starts at zero.
    mem_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_mem || mem_ready || timeout),
        .en      (in_mem && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state <= S_FETCH;
                S_FETCH:   if (mem_ready) state <= S_DECODE;
                S_DECODE:  state <= decode_target(opcode);
                S_MEM_ADR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready)    state <= S_MEM_WB;
                    else if (timeout) state <= S_FETCH;
                end
                S_MEM_WR:  if (mem_ready || timeout) state <= S_FETCH;
                S_EXEC:    state <= S_ALU_WB;
                S_BRANCH:  state <= S_FETCH;
                S_ADDI_EX: state <= S_ADDI_WB;
                S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_JUMP: state <= S_FETCH;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dest   = 1'b0;
        mem_t_reg  = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        branch     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                bus_err   = timeout;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = (decode_target(opcode) == S_FETCH);
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                bus_err = timeout;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                mem_t_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                bus_err   = timeout;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            default: ;
        endcase

        pc_en = pc_write | (branch & zero_f);
    end

    assign state_o = state;

endmodule
